// File: rtl/fsbm_search_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fsbm_search_ctrl_if
//  Purpose  : Bundles the control, compare-stage and result signals of the
//             full-search block-matching sequencer.
//  Signals  : start        - one-cycle pass request
//             row_valid    - SAD array presents a valid sum row
//             cmp_enable   - compare-stage enable
//             cmp_ctr_word - compare-stage y tag
//             cmp_out      - compare result {SAD[19:8], x[7:4], y[3:0]}
//             busy, done   - pass status / completion pulse
//             best_sad, best_mv, early_exit - pass result
//  Modports : master - the sequencer
//             slave  - SAD array, compare stage and consumer side
//  Revision : 1.0 - initial release
// ============================================================================
interface fsbm_search_ctrl_if;
   logic        start;
   logic        row_valid;
   logic        cmp_enable;
   logic [3:0]  cmp_ctr_word;
   logic [19:0] cmp_out;
   logic        busy;
   logic        done;
   logic [11:0] best_sad;
   logic [7:0]  best_mv;
   logic        early_exit;

   modport master (
      input  start, row_valid, cmp_out,
      output cmp_enable, cmp_ctr_word, busy, done, best_sad, best_mv, early_exit
   );

   modport slave (
      output start, row_valid, cmp_out,
      input  cmp_enable, cmp_ctr_word, busy, done, best_sad, best_mv, early_exit
   );
endinterface
`default_nettype wire

// File: rtl/fsbm_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fsbm_search_ctrl
//  Purpose  : Sequences one full-search block-matching pass. Issues one
//             compare enable per search row, tags each row with its y index,
//             tracks the minimum SAD and its motion vector, then reports the
//             result with a one-cycle done pulse.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - fsbm_search_ctrl_if.master (start, row_valid, cmp_*,
//                    busy, done, best_sad, best_mv, early_exit)
//  Options  : FSBM_EARLY_EXIT_EN - when defined, a captured SAD <= EARLY_THR
//             during issue stops further enables and flags early_exit.
//  Revision : 1.0 - initial release
// ============================================================================
module fsbm_search_ctrl #(
   parameter int          ROWS      = 16,
   parameter int          CMP_LAT   = 2,
   parameter logic [11:0] EARLY_THR = 12'd0
) (
   input  logic                 clk,
   input  logic                 rst,
   fsbm_search_ctrl_if.master   bus
);

   localparam int                ROW_W    = 4;
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        r_state;
   logic [ROW_W-1:0]  r_row;
   logic [ROW_W-1:0]  r_tag1;
   logic [CMP_LAT:1]  r_vld;
   logic [11:0]       r_best_sad;
   logic [7:0]        r_best_mv;
   logic              r_first;
   logic              r_early;

   logic              w_en;
   logic              w_cap;
   logic [11:0]       w_cap_sad;
   logic              w_load;
   logic              w_hit;

   assign w_cap     = r_vld[CMP_LAT];
   assign w_cap_sad = bus.cmp_out[19:8];
   // Strict compare keeps the earlier (lower y) row on a tie.
   assign w_load    = w_cap & (r_first | (w_cap_sad < r_best_sad));

`ifdef FSBM_EARLY_EXIT_EN
   assign w_hit = (r_state == S_ISSUE) & w_cap & (w_cap_sad <= EARLY_THR);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_early <= 1'b0;
      end else if ((r_state == S_IDLE) && bus.start) begin
         r_early <= 1'b0;
      end else if (w_hit) begin
         r_early <= 1'b1;
      end
   end
`else
   assign w_hit   = 1'b0;
   assign r_early = 1'b0;
`endif

   // A hit suppresses the enable in the same cycle, so only rows already
   // sampled by the compare stage remain in flight.
   assign w_en = (r_state == S_ISSUE) & bus.row_valid & ~w_hit;

   // Valid pipe: stage k is set k cycles after the enable was sampled; the
   // last stage marks the cycle in which cmp_out carries that row's result.
   generate
      if (CMP_LAT == 1) begin : g_vld_single
         always_ff @(posedge clk) begin
            if (rst) r_vld <= '0;
            else     r_vld <= w_en;
         end
      end else begin : g_vld_shift
         always_ff @(posedge clk) begin
            if (rst) r_vld <= '0;
            else     r_vld <= {r_vld[CMP_LAT-1:1], w_en};
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_row      <= '0;
         r_tag1     <= '0;
         r_best_sad <= 12'hFFF;
         r_best_mv  <= 8'h00;
         r_first    <= 1'b0;
      end else begin
         // Stage-1 tag only moves on an enable, so it stays put through
         // row_valid gaps and lines up with the compare's delayed enable.
         if (w_en) r_tag1 <= r_row;

         if (w_load) begin
            r_best_sad <= w_cap_sad;
            r_best_mv  <= bus.cmp_out[7:0];
         end
         if (w_cap) r_first <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state    <= S_ISSUE;
                  r_best_sad <= 12'hFFF;
                  r_row      <= '0;
                  r_first    <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (w_hit) begin
                  r_state <= S_DRAIN;
               end else if (w_en) begin
                  if (r_row == LAST_ROW) r_state <= S_DRAIN;
                  else                   r_row   <= r_row + 1'b1;
               end
            end
            S_DRAIN: begin
               if (~|r_vld) r_state <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cmp_enable   = w_en;
   assign bus.cmp_ctr_word = r_tag1;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.done         = (r_state == S_DONE);
   assign bus.best_sad     = r_best_sad;
   assign bus.best_mv      = r_best_mv;
   assign bus.early_exit   = r_early;

endmodule
`default_nettype wire

// File: tb/tb_fsbm_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsbm_search_ctrl
//  Purpose  : Directed self-checking bench for fsbm_search_ctrl. A small
//             compare-stage model answers each enable one cycle after the
//             stage-1 tag appears, using per-row SAD/x tables.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsbm_search_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fsbm_search_ctrl_if bus ();

   fsbm_search_ctrl #(
      .ROWS      (16),
      .CMP_LAT   (2),
      .EARLY_THR (12'd10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [11:0] sad_tab [16];
   logic [3:0]  x_tab   [16];

   // Compare-stage model plus enable/tag bookkeeping.
   logic       en_d1;
   logic [4:0] m_row;
   int         en_count;
   int         align_err;

   always @(posedge clk) begin
      if (rst || (bus.start && !bus.busy)) begin
         en_d1     <= 1'b0;
         m_row     <= '0;
         en_count  <= 0;
         align_err <= 0;
         if (rst) bus.cmp_out <= '0;
      end else begin
         en_d1 <= bus.cmp_enable;
         if (bus.cmp_enable) en_count <= en_count + 1;
         if (en_d1) begin
            bus.cmp_out <= {sad_tab[bus.cmp_ctr_word], x_tab[bus.cmp_ctr_word], bus.cmp_ctr_word};
            if (bus.cmp_ctr_word !== m_row[3:0]) align_err <= align_err + 1;
            m_row <= m_row + 5'd1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: row_valid always 1; mode 1: row_valid 1,0,1,0...;
   // mode 2: always 1 with an extra start pulse mid-pass.
   task automatic run_pass(input int mode, output int cyc);
      cyc = 0;
      bus.start     = 1'b1;
      bus.row_valid = 1'b0;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         bus.row_valid = (mode == 1) ? ((c % 2) == 1) : 1'b1;
         if (mode == 2 && c == 5) bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         if (bus.done) begin
            cyc = c;
            break;
         end
      end
      bus.row_valid = 1'b0;
   endtask

   task automatic check_result(input string tag, input int cyc, input int exp_cyc,
                               input logic [11:0] exp_sad, input logic [7:0] exp_mv,
                               input logic exp_early, input int exp_en);
      check({tag, "_done_cycle"}, cyc, exp_cyc);
      check({tag, "_best_sad"},   bus.best_sad, exp_sad);
      check({tag, "_best_mv"},    bus.best_mv, exp_mv);
      check({tag, "_early_exit"}, bus.early_exit, exp_early);
      check({tag, "_enables"},    en_count, exp_en);
      check({tag, "_tag_align"},  align_err, 0);
      tick();
      check({tag, "_done_pulse"}, bus.done, 1'b0);
      check({tag, "_busy_after"}, bus.busy, 1'b0);
      check({tag, "_held_sad"},   bus.best_sad, exp_sad);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc;
      bit  saw_en;
      bit  saw_done;

      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.row_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sad_tab[i] = 12'(100 - i);
         x_tab[i]   = 4'd3;
      end
      tick();
      tick();
      rst = 1'b0;

      // Reset / idle behaviour
      saw_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.row_valid = 1'b1;
         tick();
         if (bus.cmp_enable || bus.done || bus.busy) saw_en = 1'b1;
      end
      bus.row_valid = 1'b0;
      check("idle_quiet",   saw_en, 1'b0);
      check("rst_best_sad", bus.best_sad, 12'hFFF);
      check("rst_best_mv",  bus.best_mv, 8'h00);
      check("rst_early",    bus.early_exit, 1'b0);
      check("rst_ctr_word", bus.cmp_ctr_word, 4'h0);

      // Continuous pass, SAD = 100 - y, x = 3
      run_pass(0, cyc);
      check_result("cont", cyc, 19, 12'd85, 8'h3F, 1'b0, 16);

      // Alternating row_valid
      run_pass(1, cyc);
      check_result("gap", cyc, 34, 12'd85, 8'h3F, 1'b0, 16);

      // Tie: every row SAD 50, row 0 x = 7
      for (int i = 0; i < 16; i++) begin
         sad_tab[i] = 12'd50;
         x_tab[i]   = (i == 0) ? 4'd7 : 4'd2;
      end
      run_pass(0, cyc);
      check_result("tie", cyc, 19, 12'd50, 8'h70, 1'b0, 16);

      // Reset in the middle of a pass
      for (int i = 0; i < 16; i++) begin
         sad_tab[i] = 12'(100 - i);
         x_tab[i]   = 4'd3;
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      saw_done  = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         bus.row_valid = 1'b1;
         tick();
         if (bus.done) saw_done = 1'b1;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.row_valid = 1'b0;
      check("abort_busy",     bus.busy, 1'b0);
      check("abort_best_sad", bus.best_sad, 12'hFFF);
      for (int i = 0; i < 25; i++) begin
         tick();
         if (bus.done || bus.cmp_enable) saw_done = 1'b1;
      end
      check("abort_no_done", saw_done, 1'b0);

      // Fresh pass with an ignored start pulse while busy
      run_pass(2, cyc);
      check_result("restart", cyc, 19, 12'd85, 8'h3F, 1'b0, 16);

      // Early-exit scenario: row 4 SAD 5 with threshold 10
      sad_tab[4] = 12'd5;
      run_pass(0, cyc);
`ifdef FSBM_EARLY_EXIT_EN
      check_result("early", cyc, 9, 12'd5, 8'h34, 1'b1, 6);
`else
      check_result("early", cyc, 19, 12'd5, 8'h34, 1'b0, 16);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
